// File: rtl/sync_ram_ws_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_ws_if
//  Description : Request/response bus for the wait-state RAM: one request
//                per access, one-cycle ack carrying rdata/err, plus the busy
//                flag and the mirrored watch word.
//  Revision    : 1.0  initial release
// ============================================================================
interface sync_ram_ws_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic [DATA_W-1:0] watch;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, err, busy, watch
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, err, busy, watch
  );
endinterface
`default_nettype wire

// File: rtl/sync_ram_ws.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_ws
//  Description : Register-file RAM with a fixed number of wait states per
//                access. A request is latched in IDLE, held in WAIT for
//                WAIT_STATES cycles, then completed from RESP: the write
//                commit, the rdata load and the ack pulse all happen on the
//                edge that leaves RESP. Out-of-range addresses return err
//                with zero data and never touch memory. One word is mirrored
//                continuously on watch.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_ram_ws #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1,
  parameter int WATCH_ADDR  = 14
) (
  input  logic          clk,
  input  logic          clr_n,
  sync_ram_ws_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter start value; unused when there are no wait states.
  localparam logic [2:0]  c_WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [31:0] c_DEPTH   = DEPTH;
  localparam logic [ADDR_W-1:0] c_WATCH = ADDR_W'(WATCH_ADDR);

  state_t            r_state;
  state_t            w_next_state;
  logic [2:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_watch;
  logic              r_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_done;
  logic              w_oor;
  logic              w_commit;
  logic [31:0]       w_addr_ext;

  // Next-state decode; requests outside IDLE are simply not looked at.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          w_accept = 1'b1;
          if (WAIT_STATES > 0) w_next_state = ST_WAIT;
          else                 w_next_state = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 3'd0) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_addr_ext = 32'(r_addr);
  assign w_oor      = (w_addr_ext >= c_DEPTH);
  assign w_commit   = w_done & r_we & ~w_oor;

  // State register; reset drops any in-flight access.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Wait counter: loaded on acceptance, counts down while in WAIT.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt <= 3'd0;
    end else if (w_accept) begin
      r_cnt <= c_WS_LOAD;
    end else if ((r_state == ST_WAIT) && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Capture the request so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= bus.we;
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
    end
  end

  // Response: ack/err pulse and rdata, all produced on the edge leaving RESP.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_done;
      r_err <= w_done & w_oor;
      if (w_done) begin
        if (w_oor)      r_rdata <= '0;
        else if (!r_we) r_rdata <= r_mem[r_addr];
      end
    end
  end

  // Storage array; deliberately not reset so contents survive clr_n.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[r_addr] <= r_wdata;
  end

  // Mirror of the watched word, tracking committed writes only.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                            r_watch <= '0;
    else if (w_commit && r_addr == c_WATCH) r_watch <= r_wdata;
  end

  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;
  assign bus.busy  = (r_state != ST_IDLE);
  assign bus.watch = r_watch;

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_ram_ws
//  Description : Scoreboard bench for sync_ram_ws. Instance A uses one wait
//                state and a 48-word depth; instance B has no wait states and
//                receives back-to-back requests with req held high.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_ram_ws;

  typedef struct {
    int       id;
    int       cyc;
    int       rdata;
    int       err;
    bit       chk_rd;
  } exp_t;

  logic clk;
  logic clr_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea;
  exp_t eb;

  sync_ram_ws_if #(.ADDR_W(6), .DATA_W(8)) ifa ();
  sync_ram_ws_if #(.ADDR_W(6), .DATA_W(8)) ifb ();

  sync_ram_ws #(
    .ADDR_W(6), .DATA_W(8), .DEPTH(48), .WAIT_STATES(1), .WATCH_ADDR(14)
  ) u_dut_a (
    .clk(clk), .clr_n(clr_n), .bus(ifa)
  );

  sync_ram_ws #(
    .ADDR_W(6), .DATA_W(8), .DEPTH(64), .WAIT_STATES(0), .WATCH_ADDR(14)
  ) u_dut_b (
    .clk(clk), .clr_n(clr_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor A: every ack must match the oldest expected response.
  always @(negedge clk) begin
    if (clr_n && ifa.ack) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_ack", 1, 0);
      end else begin
        ea = q_a.pop_front();
        chk($sformatf("a%0d_ack_cycle", ea.id), cyc, ea.cyc);
        chk($sformatf("a%0d_err", ea.id), int'(ifa.err), ea.err);
        if (ea.chk_rd) chk($sformatf("a%0d_rdata", ea.id), int'(ifa.rdata), ea.rdata);
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (clr_n && ifb.ack) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_ack", 1, 0);
      end else begin
        eb = q_b.pop_front();
        chk($sformatf("b%0d_ack_cycle", eb.id), cyc, eb.cyc);
        chk($sformatf("b%0d_err", eb.id), int'(ifb.err), eb.err);
        if (eb.chk_rd) chk($sformatf("b%0d_rdata", eb.id), int'(ifb.rdata), eb.rdata);
      end
    end
  end

  // One access on instance A; optionally keeps req asserted with junk
  // fields while the access is busy, which must be ignored.
  task automatic access_a(input int id, input bit w, input int a, input int d,
                          input int exp_rd, input int exp_err, input bit chk_rd,
                          input bit pulse);
    exp_t e;
    int   n;
    @(negedge clk);
    ifa.req   = 1'b1;
    ifa.we    = w;
    ifa.addr  = 6'(a);
    ifa.wdata = 8'(d);
    e.id = id; e.cyc = cyc + 3; e.rdata = exp_rd; e.err = exp_err; e.chk_rd = chk_rd;
    q_a.push_back(e);
    @(negedge clk);
    chk($sformatf("a%0d_busy", id), int'(ifa.busy), 1);
    if (pulse) begin
      ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 6'd21; ifa.wdata = 8'h77;
    end else begin
      ifa.req = 1'b0; ifa.we = ~w; ifa.addr = ~6'(a); ifa.wdata = ~8'(d);
    end
    n = 0;
    while (!ifa.ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    ifa.req = 1'b0;
    if (!ifa.ack) chk($sformatf("a%0d_timeout", id), 0, 1);
  endtask

  initial begin
    int   k;
    int   n;
    int   ops_we [4];
    int   ops_a  [4];
    int   ops_d  [4];
    int   ops_rd [4];
    exp_t e;

    cyc = 0; n_tests = 0; n_fail = 0;
    clr_n = 1'b0;
    ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0;
    ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack",   int'(ifa.ack),   0);
    chk("rst_busy",  int'(ifa.busy),  0);
    chk("rst_err",   int'(ifa.err),   0);
    chk("rst_rdata", int'(ifa.rdata), 0);
    chk("rst_watch", int'(ifa.watch), 0);
    chk("rst_b_busy", int'(ifb.busy), 0);
    clr_n = 1'b1;

    // Basic write/read, then the watched word.
    access_a(1, 1'b1, 15, 8'h04, 0,     0, 1'b0, 1'b0);
    access_a(2, 1'b0, 15, 0,     8'h04, 0, 1'b1, 1'b0);
    chk("watch_before", int'(ifa.watch), 8'h00);
    access_a(3, 1'b1, 14, 8'h10, 0,     0, 1'b0, 1'b0);
    chk("watch_on_write", int'(ifa.watch), 8'h10);
    access_a(4, 1'b0, 14, 0,     8'h10, 0, 1'b1, 1'b0);
    chk("watch_after_read", int'(ifa.watch), 8'h10);

    // Out of range for DEPTH=48.
    access_a(5, 1'b1, 50, 8'hFF, 8'h00, 1, 1'b1, 1'b0);
    chk("watch_after_oor", int'(ifa.watch), 8'h10);
    access_a(6, 1'b0, 50, 0,     8'h00, 1, 1'b1, 1'b0);
    access_a(7, 1'b0, 15, 0,     8'h04, 0, 1'b1, 1'b0);
    access_a(8, 1'b0, 14, 0,     8'h10, 0, 1'b1, 1'b0);

    // Requests while busy are ignored (monitor flags any extra ack).
    access_a(9,  1'b1, 20, 8'h33, 0,     0, 1'b0, 1'b1);
    access_a(10, 1'b0, 20, 0,     8'h33, 0, 1'b1, 1'b0);

    // Reset during WAIT of a write drops the access.
    access_a(11, 1'b1, 3, 8'h55, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 6'd3; ifa.wdata = 8'hAA;
    @(posedge clk);
    #2;
    ifa.req = 1'b0;
    chk("pre_rst_busy", int'(ifa.busy), 1);
    clr_n = 1'b0;
    #1;
    chk("async_busy",  int'(ifa.busy),  0);
    chk("async_ack",   int'(ifa.ack),   0);
    chk("async_watch", int'(ifa.watch), 0);
    chk("async_rdata", int'(ifa.rdata), 0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    access_a(12, 1'b0, 3,  0, 8'h55, 0, 1'b1, 1'b0);
    access_a(13, 1'b0, 14, 0, 8'h10, 0, 1'b1, 1'b0);
    chk("watch_post_rst", int'(ifa.watch), 8'h00);

    // Instance B: no wait states, req held high across four accesses.
    ops_we = '{1, 1, 0, 0};
    ops_a  = '{5, 6, 5, 6};
    ops_d  = '{8'hA1, 8'hB2, 0, 0};
    ops_rd = '{0, 0, 8'hA1, 8'hB2};
    @(negedge clk);
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      e.id = 20 + i; e.cyc = k + 2 + 2 * i; e.rdata = ops_rd[i]; e.err = 0;
      e.chk_rd = (ops_we[i] == 0);
      q_b.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      ifb.req = 1'b1; ifb.we = ops_we[i][0]; ifb.addr = 6'(ops_a[i]); ifb.wdata = 8'(ops_d[i]);
      n = 0;
      @(negedge clk);
      while (!ifb.ack && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!ifb.ack) chk($sformatf("b%0d_timeout", 20 + i), 0, 1);
    end
    ifb.req = 1'b0;

    repeat (4) @(negedge clk);
    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
